// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz-buzzer arbiter: FSM state encoding,
// 7-segment patterns and counter-width helpers.
package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED,
    TIMEOUT
  } state_e;

  // Segment order {g,f,e,d,c,b,a}; a segment is lit when its bit is 0.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] CODE_DASH = 4'd15;

  function automatic int unsigned presc_width(input int unsigned clk_hz);
    return (clk_hz > 1) ? $clog2(clk_hz) : 1;
  endfunction

  function automatic int unsigned buz_width(input int unsigned buz_cyc);
    return $clog2(buz_cyc + 1);
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// 4-bit code to active-low 7-segment pattern; code 15 draws a dash, 10..14 are blank.
module seg7_dec
  import quiz_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    unique case (code_i)
      4'd0:      seg_o = SEG_0;
      4'd1:      seg_o = SEG_1;
      4'd2:      seg_o = SEG_2;
      4'd3:      seg_o = SEG_3;
      4'd4:      seg_o = SEG_4;
      4'd5:      seg_o = SEG_5;
      4'd6:      seg_o = SEG_6;
      4'd7:      seg_o = SEG_7;
      4'd8:      seg_o = SEG_8;
      4'd9:      seg_o = SEG_9;
      CODE_DASH: seg_o = SEG_DASH;
      default:   seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/quiz_arbiter.sv
// N-channel quiz-buzzer arbiter: first eligible press after arming wins, with
// answer countdown, timeout, false-start lockout and fixed-length buzzer pulse.
module quiz_arbiter
  import quiz_pkg::*;
#(
  parameter int unsigned N_CH           = 8,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned ANS_SEC        = 9,
  parameter int unsigned BUZ_CYC        = 10_000_000,
  parameter int unsigned FALSE_START_EN = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ask,
  input  logic [N_CH-1:0] i_ans,
  output logic [6:0]      o_seg,
  output logic            o_buz,
  output logic [3:0]      o_winner,
  output logic            o_valid,
  output logic [N_CH-1:0] o_foul
);

  localparam int unsigned PW = presc_width(CLK_HZ);
  localparam int unsigned BW = buz_width(BUZ_CYC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [1:0]      ask_s_q;
  logic            ask_prev_q;
  logic [N_CH-1:0] ans_s1_q, ans_s2_q;

  state_e          state_q, state_d;
  logic [3:0]      sec_q, sec_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   buz_q, buz_d;
  logic [3:0]      winner_q, winner_d;
  logic            valid_q, valid_d;
  logic [N_CH-1:0] foul_q, foul_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      code_d;

  logic            ask_edge;
  logic [N_CH-1:0] pressed, elig;
  logic            win_hit;
  logic [3:0]      win_num;

  assign ask_edge = ask_s_q[1] & ~ask_prev_q;
  assign pressed  = ~ans_s2_q;
  assign elig     = pressed & ~foul_q;

  // Scan downward so the lowest eligible channel is the last one written.
  always_comb begin
    win_hit = 1'b0;
    win_num = '0;
    for (int unsigned k = N_CH; k > 0; k--) begin
      if (elig[k-1]) begin
        win_hit = 1'b1;
        win_num = 4'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    presc_d  = presc_q;
    buz_d    = (buz_q != '0) ? buz_q - BW'(1) : buz_q;
    winner_d = winner_q;
    valid_d  = valid_q;
    foul_d   = foul_q;

    unique case (state_q)
      IDLE: begin
        if (FALSE_START_EN != 0) foul_d = foul_q | pressed;
        if (ask_edge) begin
          state_d = ARMED;
          sec_d   = 4'(ANS_SEC);
          presc_d = '0;
        end
      end
      ARMED: begin
        // A press outranks a countdown expiry landing in the same cycle.
        if (win_hit) begin
          state_d  = LOCKED;
          winner_d = win_num;
          valid_d  = 1'b1;
          buz_d    = BW'(BUZ_CYC);
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          sec_d   = sec_q - 4'd1;
          if (sec_q == 4'd1) begin
            state_d = TIMEOUT;
            buz_d   = BW'(BUZ_CYC);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      LOCKED, TIMEOUT: begin
        if (ask_edge) begin
          state_d  = IDLE;
          winner_d = '0;
          valid_d  = 1'b0;
          foul_d   = '0;
          buz_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      ARMED:   code_d = sec_d;
      LOCKED:  code_d = winner_d;
      TIMEOUT: code_d = 4'd0;
      default: code_d = CODE_DASH;
    endcase
  end

  seg7_dec u_seg7_dec (
    .code_i (code_d),
    .seg_o  (seg_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ask_s_q    <= '0;
      ask_prev_q <= 1'b0;
      ans_s1_q   <= '1;
      ans_s2_q   <= '1;
      state_q    <= IDLE;
      sec_q      <= '0;
      presc_q    <= '0;
      buz_q      <= '0;
      winner_q   <= '0;
      valid_q    <= 1'b0;
      foul_q     <= '0;
      seg_q      <= SEG_DASH;
    end else begin
      ask_s_q    <= {ask_s_q[0], i_ask};
      ask_prev_q <= ask_s_q[1];
      ans_s1_q   <= i_ans;
      ans_s2_q   <= ans_s1_q;
      state_q    <= state_d;
      sec_q      <= sec_d;
      presc_q    <= presc_d;
      buz_q      <= buz_d;
      winner_q   <= winner_d;
      valid_q    <= valid_d;
      foul_q     <= foul_d;
      seg_q      <= seg_d;
    end
  end

  assign o_seg    = seg_q;
  assign o_buz    = (buz_q != '0);
  assign o_winner = winner_q;
  assign o_valid  = valid_q;
  assign o_foul   = foul_q;

endmodule

// File: tb/tb_quiz_arbiter.sv
// Directed self-checking bench for quiz_arbiter with a short countdown and buzzer.
module tb_quiz_arbiter;

  logic       clk;
  logic       rst_n;
  logic       ask;
  logic [7:0] ans;
  logic [6:0] seg;
  logic       buz;
  logic [3:0] winner;
  logic       valid;
  logic [7:0] foul;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [6:0] S_DASH = 7'b0111111;
  localparam logic [6:0] S_0    = 7'b1000000;
  localparam logic [6:0] S_1    = 7'b1111001;
  localparam logic [6:0] S_2    = 7'b0100100;
  localparam logic [6:0] S_3    = 7'b0110000;
  localparam logic [6:0] S_5    = 7'b0010010;
  localparam logic [6:0] S_8    = 7'b0000000;

  quiz_arbiter #(
    .N_CH           (8),
    .CLK_HZ         (100),
    .ANS_SEC        (3),
    .BUZ_CYC        (10),
    .FALSE_START_EN (1)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_ask    (ask),
    .i_ans    (ans),
    .o_seg    (seg),
    .o_buz    (buz),
    .o_winner (winner),
    .o_valid  (valid),
    .o_foul   (foul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Ask pulse; on return the state change has just happened (3 edges).
  task automatic ask_pulse();
    ask = 1'b1;
    tick(3);
    ask = 1'b0;
  endtask

  // Counts buzzer-high cycles starting at the current (already high) sample.
  task automatic count_buz(output int unsigned n);
    n = 0;
    for (int unsigned i = 0; i < 30; i++) begin
      if (!buz) break;
      n++;
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ask = 1'b0; ans = 8'hFF;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checks++; if (seg !== S_DASH) begin errors++; $display("FAIL reset_seg: got %b want %b", seg, S_DASH); end
    checks++; if (buz !== 1'b0) begin errors++; $display("FAIL reset_buz: got %b want 0", buz); end
    checks++; if (winner !== 4'd0) begin errors++; $display("FAIL reset_winner: got %0d want 0", winner); end
    checks++; if (valid !== 1'b0 || foul !== 8'h00) begin errors++; $display("FAIL reset_valid_foul: got %b/%h want 0/00", valid, foul); end
  endtask

  task automatic test_single_press();
    int unsigned n;
    ask_pulse();
    checks++; if (seg !== S_3) begin errors++; $display("FAIL armed_seg: got %b want %b", seg, S_3); end
    ans = 8'hFB;
    tick(2);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL press_early: valid got %b want 0", valid); end
    tick(1);
    checks++; if (winner !== 4'd3 || valid !== 1'b1) begin errors++; $display("FAIL press_winner: got %0d/%b want 3/1", winner, valid); end
    checks++; if (seg !== S_3) begin errors++; $display("FAIL press_seg: got %b want %b", seg, S_3); end
    ans = 8'hFF;
    count_buz(n);
    checks++; if (n != 10) begin errors++; $display("FAIL press_buz_len: got %0d want 10", n); end
    ask_pulse();
    checks++; if (valid !== 1'b0 || winner !== 4'd0 || seg !== S_DASH) begin errors++; $display("FAIL press_clear: got %b/%0d/%b want 0/0/%b", valid, winner, seg, S_DASH); end
    tick(2);
  endtask

  task automatic test_tie();
    ask_pulse();
    ans = 8'hDD;
    tick(3);
    checks++; if (winner !== 4'd2) begin errors++; $display("FAIL tie_winner: got %0d want 2", winner); end
    ans = 8'hDC;
    tick(4);
    checks++; if (winner !== 4'd2) begin errors++; $display("FAIL tie_late_press: got %0d want 2", winner); end
    ans = 8'hFF;
    tick(3);
    ask_pulse();
    tick(2);
  endtask

  task automatic test_false_start();
    ans = 8'hFE;
    tick(3);
    checks++; if (foul !== 8'h01) begin errors++; $display("FAIL foul_idle: got %h want 01", foul); end
    ask_pulse();
    tick(5);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL foul_lockout: valid got %b want 0", valid); end
    ans = 8'hEE;
    tick(3);
    checks++; if (winner !== 4'd5 || foul !== 8'h01 || seg !== S_5) begin errors++; $display("FAIL foul_winner: got %0d/%h/%b want 5/01/%b", winner, foul, seg, S_5); end
    ans = 8'hFF;
    tick(3);
    ask_pulse();
    tick(2);
    checks++; if (foul !== 8'h00) begin errors++; $display("FAIL foul_clear: got %h want 00", foul); end
  endtask

  task automatic test_timeout();
    int unsigned n;
    ask_pulse();
    tick(99);
    checks++; if (seg !== S_3) begin errors++; $display("FAIL cd_hold3: got %b want %b", seg, S_3); end
    tick(1);
    checks++; if (seg !== S_2) begin errors++; $display("FAIL cd_step2: got %b want %b", seg, S_2); end
    tick(100);
    checks++; if (seg !== S_1) begin errors++; $display("FAIL cd_step1: got %b want %b", seg, S_1); end
    tick(99);
    checks++; if (seg !== S_1 || buz !== 1'b0) begin errors++; $display("FAIL cd_pre_expiry: got %b/%b want %b/0", seg, buz, S_1); end
    tick(1);
    checks++; if (seg !== S_0 || winner !== 4'd0 || valid !== 1'b0) begin errors++; $display("FAIL cd_timeout: got %b/%0d/%b want %b/0/0", seg, winner, valid, S_0); end
    count_buz(n);
    checks++; if (n != 10) begin errors++; $display("FAIL cd_buz_len: got %0d want 10", n); end
    ans = 8'hF0;
    tick(3);
    checks++; if (winner !== 4'd0) begin errors++; $display("FAIL cd_press_ignored: got %0d want 0", winner); end
    ans = 8'hFF;
    tick(3);
    ask_pulse();
    tick(2);
  endtask

  task automatic test_press_at_expiry();
    ask_pulse();
    tick(297);
    ans = 8'h7F;
    tick(3);
    checks++; if (winner !== 4'd8 || valid !== 1'b1 || seg !== S_8) begin errors++; $display("FAIL expiry_press: got %0d/%b/%b want 8/1/%b", winner, valid, seg, S_8); end
    ans = 8'hFF;
    tick(3);
    ask_pulse();
    tick(2);
  endtask

  task automatic test_all_fouled();
    ans = 8'h00;
    tick(3);
    ask_pulse();
    tick(299);
    checks++; if (valid !== 1'b0 || seg !== S_1) begin errors++; $display("FAIL allfoul_armed: got %b/%b want 0/%b", valid, seg, S_1); end
    tick(1);
    checks++; if (seg !== S_0 || winner !== 4'd0 || foul !== 8'hFF) begin errors++; $display("FAIL allfoul_timeout: got %b/%0d/%h want %b/0/ff", seg, winner, foul, S_0); end
    ans = 8'hFF;
    tick(3);
    ask_pulse();
    tick(2);
  endtask

  task automatic test_abort_buzz();
    ask_pulse();
    ans = 8'hFE;
    tick(3);
    ans = 8'hFF;
    checks++; if (buz !== 1'b1 || winner !== 4'd1) begin errors++; $display("FAIL abort_locked: got %b/%0d want 1/1", buz, winner); end
    tick(2);
    ask = 1'b1;
    tick(2);
    checks++; if (buz !== 1'b1) begin errors++; $display("FAIL abort_midbuz: got %b want 1", buz); end
    tick(1);
    ask = 1'b0;
    checks++; if (buz !== 1'b0 || valid !== 1'b0 || seg !== S_DASH) begin errors++; $display("FAIL abort_idle: got %b/%b/%b want 0/0/%b", buz, valid, seg, S_DASH); end
    tick(2);
  endtask

  task automatic test_async_reset();
    ask_pulse();
    ans = 8'hFE;
    tick(1);
    ans = 8'hFF;
    tick(1);
    checks++; if (seg !== S_3) begin errors++; $display("FAIL rst_pre_armed: got %b want %b", seg, S_3); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (seg !== S_DASH || buz !== 1'b0 || winner !== 4'd0 || valid !== 1'b0 || foul !== 8'h00)
      begin errors++; $display("FAIL rst_async: got %b/%b/%0d/%b/%h want %b/0/0/0/00", seg, buz, winner, valid, foul, S_DASH); end
    tick(2);
    checks++; if (valid !== 1'b0 || seg !== S_DASH) begin errors++; $display("FAIL rst_held: got %b/%b want 0/%b", valid, seg, S_DASH); end
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0; ask = 1'b0; ans = 8'hFF;
    test_reset();
    test_single_press();
    test_tie();
    test_false_start();
    test_timeout();
    test_press_at_expiry();
    test_all_fouled();
    test_abort_buzz();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
